// File: rtl/lcd_msg_arbiter_pkg.sv
// Shared definitions for the LCD message arbiter and the line-buffer formatter.
// - arb_state_e : arbiter FSM states.
// - MSG_*       : message IDs. These are also the arbiter request indices, so
//                 req[MSG_x] is the request line of that message and sel_id
//                 can be used directly as the formatter case selector.
package lcd_msg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,  // nothing shown, formatter renders ODO/FUEL
        ST_SHOW   = 2'd1,  // owner on screen
        ST_SWITCH = 2'd2   // new owner decided, waiting for a frame boundary
    } arb_state_e;

    // Index 0 is the urgent source; it preempts every other message.
    localparam int MSG_OIL_PRESS  = 0;
    localparam int MSG_ENGINE_ON  = 1;
    localparam int MSG_SIDE_BRAKE = 2;
    localparam int MSG_LOW_FUEL   = 3;

endpackage

// File: rtl/lcd_msg_arbiter_if.sv
// Handshake bundle between the message sources / LCD driver and the arbiter.
// - master : drives enable, req, frame_done; observes the selection.
// - slave  : the arbiter; drives sel_valid, sel_id, sel_onehot, switch_pending.
interface lcd_msg_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int IDW = $clog2(N_REQ);

    logic             enable;
    logic [N_REQ-1:0] req;
    logic             frame_done;
    logic             sel_valid;
    logic [IDW-1:0]   sel_id;
    logic [N_REQ-1:0] sel_onehot;
    logic             switch_pending;

    modport master (
        output enable, req, frame_done,
        input  sel_valid, sel_id, sel_onehot, switch_pending
    );

    modport slave (
        input  enable, req, frame_done,
        output sel_valid, sel_id, sel_onehot, switch_pending
    );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond tick prescaler.
// - clk, rst_n : clock, asynchronous active-low reset.
// - ms_tick    : one-cycle pulse every CLK_HZ/1000 cycles (every cycle when
//                CLK_HZ/1000 == 1).
module ms_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic ms_tick
);
    localparam int DIV = CLK_HZ / 1000;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign ms_tick = (cnt == LAST);
endmodule

// File: rtl/lcd_msg_arbiter.sv
// Round-robin owner selection for the shared 16x2 LCD, with urgent preemption
// on request 0 and ownership changes aligned to LCD frame boundaries.
// - clk, rst_n : clock, asynchronous active-low reset.
// - bus        : enable, req, frame_done in; sel_valid, sel_id, sel_onehot,
//                switch_pending out (all outputs registered).
module lcd_msg_arbiter
    import lcd_msg_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int CLK_HZ  = 50_000_000,
    parameter int SLOT_MS = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_msg_arbiter_if.slave  bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam logic [15:0] SLOT_END = 16'(SLOT_MS);

    arb_state_e       state;
    logic             sel_valid_q;
    logic [IDW-1:0]   sel_id_q;
    logic [N_REQ-1:0] sel_onehot_q;
    logic             pending_q;
    logic [15:0]      slot_cnt;
    logic             ms_tick;

    ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .ms_tick (ms_tick)
    );

    logic [N_REQ-1:0] act;
    logic             slot_full;
    logic             switch_cond;
    logic             do_commit;
    logic [IDW-1:0]   tgt;
    logic             tgt_found;

    assign act       = bus.req & {N_REQ{bus.enable}};
    assign slot_full = (slot_cnt == SLOT_END);

    // Switch causes while showing: owner dropped, urgent preempts a non-urgent
    // owner, or the slot expired while someone else is waiting.
    assign switch_cond = !act[sel_id_q]
                       || (act[0] && (sel_id_q != '0))
                       || (slot_full && |(act & ~sel_onehot_q));

    assign do_commit = bus.frame_done
                     && ((state == ST_SWITCH) || ((state == ST_SHOW) && switch_cond));

    // Next owner: urgent first, otherwise the first active index after the
    // current owner with wrap. With no owner on screen the scan starts at 0.
    // NOTE: every variable written here gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        int             start;
        logic [IDW-1:0] idx;
        tgt       = '0;
        tgt_found = 1'b0;
        idx       = '0;
        start     = sel_valid_q ? int'(sel_id_q) + 1 : 0;
        if (act[0]) begin
            tgt_found = 1'b1;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = IDW'((start + k) % N_REQ);
                if (!tgt_found && act[idx]) begin
                    tgt       = idx;
                    tgt_found = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            sel_valid_q  <= 1'b0;
            sel_id_q     <= '0;
            sel_onehot_q <= '0;
            pending_q    <= 1'b0;
            slot_cnt     <= '0;
        end else begin
            if (ms_tick && !slot_full) begin
                slot_cnt <= slot_cnt + 16'd1;
            end

            if (do_commit) begin
                pending_q <= 1'b0;
                slot_cnt  <= '0;
                if (tgt_found) begin
                    state        <= ST_SHOW;
                    sel_valid_q  <= 1'b1;
                    sel_id_q     <= tgt;
                    sel_onehot_q <= N_REQ'(1) << tgt;
                end else begin
                    // sel_id keeps its last value; sel_onehot marks "no owner".
                    state        <= ST_IDLE;
                    sel_valid_q  <= 1'b0;
                    sel_onehot_q <= '0;
                end
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (|act) begin
                            state     <= ST_SWITCH;
                            pending_q <= 1'b1;
                        end
                    end
                    ST_SHOW: begin
                        if (switch_cond) begin
                            state     <= ST_SWITCH;
                            pending_q <= 1'b1;
                        end else if (slot_full) begin
                            // Lone requester: restart its slot, no visible change.
                            slot_cnt <= '0;
                        end
                    end
                    ST_SWITCH: ;  // wait for frame_done, however long it takes
                    default: begin
                        state     <= ST_IDLE;
                        pending_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sel_valid      = sel_valid_q;
    assign bus.sel_id         = sel_id_q;
    assign bus.sel_onehot     = sel_onehot_q;
    assign bus.switch_pending = pending_q;
endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// Directed bench for lcd_msg_arbiter with CLK_HZ=1000 (ms tick every cycle),
// SLOT_MS=4, N_REQ=4. Inputs change on the falling edge, outputs are checked
// on the falling edge; frame_done pulses are placed explicitly per scenario.
module tb_lcd_msg_arbiter;
    import lcd_msg_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    lcd_msg_arbiter_if #(.N_REQ(4)) bus ();

    lcd_msg_arbiter #(
        .N_REQ   (4),
        .CLK_HZ  (1000),
        .SLOT_MS (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock with frame_done driven to fd; returns at the next falling edge.
    task automatic cycle(input logic fd);
        bus.frame_done = fd;
        @(negedge clk);
        bus.frame_done = 1'b0;
    endtask

    initial begin
        logic [1:0] rr_prev [3];
        logic [1:0] rr_next [3];
        rr_prev = '{2'd1, 2'd3, 2'd1};
        rr_next = '{2'd3, 2'd1, 2'd3};

        rst_n          = 1'b0;
        bus.enable     = 1'b0;
        bus.req        = 4'b0000;
        bus.frame_done = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_valid",   32'(bus.sel_valid), 0);
        check("rst_id",      32'(bus.sel_id), 0);
        check("rst_onehot",  32'(bus.sel_onehot), 0);
        check("rst_pending", 32'(bus.switch_pending), 0);
        rst_n = 1'b1;
        cycle(1'b0);

        // Single request: owner 2 after the next frame_done, survives slot expiries.
        bus.enable = 1'b1;
        bus.req    = 4'b0100;
        cycle(1'b0);
        check("single_pend", 32'(bus.switch_pending), 1);
        check("single_wait_valid", 32'(bus.sel_valid), 0);
        cycle(1'b1);
        check("single_id",     32'(bus.sel_id), 2);
        check("single_valid",  32'(bus.sel_valid), 1);
        check("single_onehot", 32'(bus.sel_onehot), 32'b0100);
        check("single_pend0",  32'(bus.switch_pending), 0);
        for (int i = 0; i < 12; i++) begin
            cycle((i % 3) == 2);
            check("single_hold_id",   32'(bus.sel_id), 2);
            check("single_hold_pend", 32'(bus.switch_pending), 0);
        end

        // Drop the request: release after the following frame_done.
        bus.req = 4'b0000;
        cycle(1'b0);
        check("drop_pend",  32'(bus.switch_pending), 1);
        check("drop_valid", 32'(bus.sel_valid), 1);
        cycle(1'b1);
        check("drop_valid0",  32'(bus.sel_valid), 0);
        check("drop_onehot0", 32'(bus.sel_onehot), 0);
        check("drop_pend0",   32'(bus.switch_pending), 0);

        // Round-robin between 1 and 3, frame_done every 3 cycles.
        bus.req = 4'b1010;
        cycle(1'b0);
        cycle(1'b1);
        check("rr_first", 32'(bus.sel_id), 1);
        for (int r = 0; r < 3; r++) begin
            for (int c = 1; c <= 6; c++) begin
                cycle(c == 3 || c == 6);
                check("rr_id",   32'(bus.sel_id), (c == 6) ? 32'(rr_next[r]) : 32'(rr_prev[r]));
                check("rr_pend", 32'(bus.switch_pending), (c == 5) ? 1 : 0);
            end
        end

        // Urgent preempt with owner 3 and the slot counter at 1.
        cycle(1'b0);
        bus.req = 4'b1011;
        cycle(1'b0);
        check("urg_pend", 32'(bus.switch_pending), 1);
        check("urg_hold", 32'(bus.sel_id), 3);
        cycle(1'b1);
        check("urg_id",     32'(bus.sel_id), 0);
        check("urg_onehot", 32'(bus.sel_onehot), 32'b0001);
        check("urg_pend0",  32'(bus.switch_pending), 0);

        // Frame gating: owner 0 drops, no frame_done for 20 cycles.
        bus.req = 4'b1010;
        cycle(1'b0);
        check("gate_pend", 32'(bus.switch_pending), 1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0);
            check("gate_id",   32'(bus.sel_id), 0);
            check("gate_pend", 32'(bus.switch_pending), 1);
        end
        cycle(1'b1);
        check("gate_commit", 32'(bus.sel_id), 1);
        check("gate_pend0",  32'(bus.switch_pending), 0);

        // enable=0 releases the display even with every request up.
        bus.req    = 4'b1111;
        bus.enable = 1'b0;
        cycle(1'b0);
        check("en0_pend",  32'(bus.switch_pending), 1);
        check("en0_valid", 32'(bus.sel_valid), 1);
        cycle(1'b1);
        check("en0_valid0",  32'(bus.sel_valid), 0);
        check("en0_onehot0", 32'(bus.sel_onehot), 0);
        bus.enable = 1'b1;
        cycle(1'b0);
        check("en1_pend", 32'(bus.switch_pending), 1);
        cycle(1'b1);
        check("en1_id",     32'(bus.sel_id), MSG_OIL_PRESS);
        check("en1_onehot", 32'(bus.sel_onehot), 32'b0001);

        // Reset mid-SHOW with owner 2: outputs clear without a clock edge.
        bus.req = 4'b0100;
        cycle(1'b0);
        cycle(1'b1);
        check("pre_rst_id", 32'(bus.sel_id), MSG_SIDE_BRAKE);
        cycle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",   32'(bus.sel_valid), 0);
        check("arst_onehot",  32'(bus.sel_onehot), 0);
        check("arst_pending", 32'(bus.switch_pending), 0);
        check("arst_id",      32'(bus.sel_id), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
